// File: rtl/iterative_shifter_if.sv
// Start/result-ready handshake between the processor and the iterative shifter.
// The processor drives the master side; the shifter implements the slave side.
interface iterative_shifter_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic               ctrl_shift;
  logic [WIDTH-1:0]   data_operandA;
  logic [SHAMT_W-1:0] data_shamt;
  logic [1:0]         data_op;
  logic [WIDTH-1:0]   data_result;
  logic               data_resultRDY;
  logic               busy;

  modport master (
    output ctrl_shift, data_operandA, data_shamt, data_op,
    input  data_result, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_shift, data_operandA, data_shamt, data_op,
    output data_result, data_resultRDY, busy
  );
endinterface

// File: rtl/iterative_shifter.sv
// Multicycle SLL/SRA/SRL/ROR unit: one binary shift stage (16/8/4/2/1) per clock,
// fixed 5-edge latency from start to the one-cycle result-ready pulse.
module iterative_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic          clock,
  input  logic          reset,
  iterative_shifter_if.slave sh
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b01;
  localparam logic [1:0] OP_SRL = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   work;
  logic [SHAMT_W-1:0] shamt_q;
  logic [1:0]         op_q;
  logic [2:0]         idx;
  logic [WIDTH-1:0]   result_q;
  logic               rdy_q;
  logic               busy_q;
  logic [WIDTH-1:0]   work_next;

  // Apply the single stage of weight 2^k; SRA takes its fill from the stage input's MSB.
  function automatic logic [WIDTH-1:0] stage_shift(
    input logic [WIDTH-1:0] w,
    input logic [1:0]       op,
    input logic [2:0]       k
  );
    int n;
    logic signed [WIDTH-1:0] ws;
    n  = 1 << k;
    ws = w;
    case (op)
      OP_SLL:  return w << n;
      OP_SRA:  return ws >>> n;
      OP_SRL:  return w >> n;
      OP_ROR:  return (w >> n) | (w << (WIDTH - n));
      default: return w;
    endcase
  endfunction

  always_comb begin
    work_next = work;
    if (shamt_q[idx])
      work_next = stage_shift(work, op_q, idx);
  end

  // A start in any state (including mid-shift or DONE) reloads the work registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      work     <= '0;
      shamt_q  <= '0;
      op_q     <= '0;
      idx      <= '0;
      result_q <= '0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      if (sh.ctrl_shift) begin
        work    <= sh.data_operandA;
        shamt_q <= sh.data_shamt;
        op_q    <= sh.data_op;
        idx     <= 3'd4;
        busy_q  <= 1'b1;
        state   <= SHIFT;
      end else begin
        case (state)
          IDLE: begin
            state <= IDLE;
          end
          SHIFT: begin
            work <= work_next;
            if (idx == 3'd0) begin
              result_q <= work_next;
              rdy_q    <= 1'b1;
              busy_q   <= 1'b0;
              state    <= DONE;
            end else begin
              idx <= idx - 3'd1;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sh.data_result    = result_q;
  assign sh.data_resultRDY = rdy_q;
  assign sh.busy           = busy_q;

endmodule

// File: tb/tb_iterative_shifter.sv
// Randomized and directed bench for iterative_shifter against an arithmetic shift model.
`timescale 1ns/1ps
module tb_iterative_shifter;

  logic clock;
  logic reset;

  iterative_shifter_if #(.WIDTH(32), .SHAMT_W(5)) sif ();

  iterative_shifter #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clock (clock),
    .reset (reset),
    .sh    (sif.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] a, input logic [4:0] s, input logic [1:0] op);
    logic [31:0] r;
    r = a;
    case (op)
      2'b00: r = a << s;
      2'b01: r = $signed(a) >>> s;
      2'b10: r = a >> s;
      default: for (int i = 0; i < int'(s); i++) r = {r[0], r[31:1]};
    endcase
    return r;
  endfunction

  task automatic scramble();
    sif.data_operandA = $urandom;
    sif.data_shamt    = 5'($urandom);
    sif.data_op       = 2'($urandom);
  endtask

  // Called at a falling edge; the start is sampled by the next rising edge (E0).
  task automatic start(input logic [31:0] a, input logic [4:0] s, input logic [1:0] op);
    sif.ctrl_shift    = 1'b1;
    sif.data_operandA = a;
    sif.data_shamt    = s;
    sif.data_op       = op;
    @(negedge clock);
    sif.ctrl_shift = 1'b0;
    scramble();
  endtask

  // Returns at the falling edge where RDY is seen; latency counts rising edges after E0.
  task automatic wait_result(input string tag, input logic [31:0] exp);
    int lat  = 0;
    int bcnt = 0;
    if (sif.busy) bcnt++;
    while (!sif.data_resultRDY && lat < 20) begin
      @(negedge clock);
      lat++;
      if (sif.busy) bcnt++;
      scramble();
    end
    check({tag, "_latency"}, 32'(lat), 32'd5);
    check({tag, "_result"}, sif.data_result, exp);
    check({tag, "_busycyc"}, 32'(bcnt), 32'd5);
  endtask

  task automatic after_done(input string tag, input logic [31:0] exp);
    @(negedge clock);
    check({tag, "_rdy_drop"}, 32'(sif.data_resultRDY), 32'd0);
    check({tag, "_hold"}, sif.data_result, exp);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [4:0] s, input logic [1:0] op);
    logic [31:0] e;
    e = model(a, s, op);
    start(a, s, op);
    wait_result(tag, e);
    after_done(tag, e);
  endtask

  initial begin
    logic [31:0] e1, e2, a;
    logic [4:0]  s;
    logic [1:0]  op;
    int          extra;

    sif.ctrl_shift = 1'b0;
    sif.data_operandA = '0;
    sif.data_shamt = '0;
    sif.data_op = '0;
    reset = 1'b1;
    #1;
    check("reset_result", sif.data_result, 32'h0);
    check("reset_rdy", 32'(sif.data_resultRDY), 32'd0);
    check("reset_busy", 32'(sif.busy), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    run_op("sra_16", 32'h8000_0000, 5'd16, 2'b01);
    check("sra_16_const", sif.data_result, 32'hFFFF_8000);
    run_op("sll_31", 32'h0000_0001, 5'd31, 2'b00);
    check("sll_31_const", sif.data_result, 32'h8000_0000);
    run_op("srl_4", 32'hF000_0000, 5'd4, 2'b10);
    check("srl_4_const", sif.data_result, 32'h0F00_0000);
    run_op("ror_4", 32'h0000_000F, 5'd4, 2'b11);
    check("ror_4_const", sif.data_result, 32'hF000_0000);
    run_op("sra_0", 32'h1234_5678, 5'd0, 2'b01);
    check("sra_0_const", sif.data_result, 32'h1234_5678);
    run_op("sra_31", 32'h8000_0001, 5'd31, 2'b01);
    run_op("ror_31", 32'h8000_0001, 5'd31, 2'b11);

    // Restart at E2: the first op must never produce RDY.
    start(32'hFFFF_FFFF, 5'd1, 2'b10);
    @(negedge clock);
    start(32'h0000_0003, 5'd2, 2'b00);
    wait_result("restart", 32'h0000_000C);
    after_done("restart", 32'h0000_000C);
    extra = 0;
    repeat (6) begin
      @(negedge clock);
      if (sif.data_resultRDY) extra++;
    end
    check("restart_no_extra_rdy", 32'(extra), 32'd0);

    // Async reset between edges in the middle of a shift.
    start(32'h0000_00F0, 5'd3, 2'b00);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("areset_result", sif.data_result, 32'h0);
    check("areset_busy", 32'(sif.busy), 32'd0);
    check("areset_rdy", 32'(sif.data_resultRDY), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    extra = 0;
    repeat (8) begin
      @(negedge clock);
      if (sif.data_resultRDY || sif.busy) extra++;
    end
    check("areset_no_rdy", 32'(extra), 32'd0);
    run_op("post_reset", 32'hCAFE_BABE, 5'd7, 2'b11);

    // Back-to-back: new start driven during the DONE cycle.
    e1 = model(32'hDEAD_BEEF, 5'd9, 2'b01);
    e2 = model(32'h0F0F_1234, 5'd13, 2'b11);
    start(32'hDEAD_BEEF, 5'd9, 2'b01);
    wait_result("b2b_first", e1);
    start(32'h0F0F_1234, 5'd13, 2'b11);
    wait_result("b2b_second", e2);
    after_done("b2b_second", e2);

    for (int i = 0; i < 40; i++) begin
      a  = $urandom;
      s  = 5'($urandom);
      op = 2'($urandom);
      run_op($sformatf("rand%0d_op%0d_s%0d", i, op, s), a, s, op);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
